// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//   Time-multiplexed scan controller for a bank of common-anode seven-segment
//   digits sharing one hexConverter. A display value is posted into a shadow
//   register and moved into the active register at the next frame boundary.
//   One digit is shown per slot of DIV cycles. The first BLANK cycles of each
//   slot keep every anode off, so the previous digit does not ghost into the
//   next one. Leading zeros can optionally be blanked.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   value_in     4*DIGITS  nibble i drives digit i (digit 0 = least significant)
//   dp_in        DIGITS    decimal point request per digit (1 = lit)
//   load         1         strobe: capture value_in/dp_in into the shadow
//   enable       1         1 = scan, 0 = display dark, scan held at digit 0
//   lz_suppress  1         1 = blank leading zero digits
//   an           DIGITS    anodes, active-low
//   seg          7         segments {g,f,e,d,c,b,a}, active-low
//   dp           1         decimal point, active-low
//   busy         1         shadow holds a value not yet displayed
//   frame_tick   1         one-cycle pulse per frame boundary
//
// All outputs are registered and show the scan state of the previous cycle.
// frame_tick follows the same rule: it is high in the cycle after the
// boundary state. That is the same cycle in which busy has just cleared.
// -----------------------------------------------------------------------------

// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hexConverter (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  always_comb begin
    unique case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      default: o_seg = 7'h0E;
    endcase
  end
endmodule

module seg_scan_controller #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  lz_suppress,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  busy,
  output logic                  frame_tick
);

  localparam int CNTW = $clog2(DIV);
  localparam int IDXW = $clog2(DIGITS);
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0] CNT_BLANK = CNTW'(BLANK);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DIGITS - 1);

  logic [CNTW-1:0]       r_cnt;
  logic [IDXW-1:0]       r_idx;
  logic                  r_busy;
  logic [4*DIGITS-1:0]   r_shadow_val;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic [4*DIGITS-1:0]   r_active_val;
  logic [DIGITS-1:0]     r_active_dp;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_tick;

  logic [CNTW-1:0]       w_cnt_next;
  logic [IDXW-1:0]       w_idx_next;
  logic                  w_boundary;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg_dec;
  logic                  w_dp_bit;
  logic [DIGITS-1:0]     w_supp;
  logic                  w_zero_above;
  logic                  w_lit;
  logic [DIGITS-1:0]     w_an_next;
  logic                  w_dp_next;

  assign w_boundary = enable && (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);
  assign w_nibble   = r_active_val[4*r_idx +: 4];
  assign w_dp_bit   = r_active_dp[r_idx];

  hexConverter u_hex (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

  // Scan position: held at digit 0 / slot start while disabled so the first
  // enabled cycle always begins a fresh digit-0 slot.
  always_comb begin
    w_cnt_next = r_cnt;
    w_idx_next = r_idx;
    if (!enable) begin
      w_cnt_next = '0;
      w_idx_next = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_next = '0;
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Leading-zero mask: walk down from the top digit while every nibble seen
  // so far is zero. Digit 0 is never suppressed.
  always_comb begin
    w_supp       = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above && (r_active_val[4*i +: 4] == 4'h0);
      w_supp[i]    = lz_suppress && w_zero_above;
    end
  end

  // Output decode for the current scan state; registered below.
  always_comb begin
    w_lit     = enable && (r_cnt >= CNT_BLANK) && !w_supp[r_idx];
    w_an_next = '1;
    if (w_lit) begin
      w_an_next[r_idx] = 1'b0;
    end
    w_dp_next = w_lit ? ~w_dp_bit : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_active_val <= '0;
      r_active_dp  <= '0;
      r_an         <= '1;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_idx <= w_idx_next;

      if (load) begin
        r_shadow_val <= value_in;
        r_shadow_dp  <= dp_in;
      end

      // A load on the boundary cycle still sees the old shadow here. The
      // new value remains pending because load takes priority on busy.
      if (w_boundary && r_busy) begin
        r_active_val <= r_shadow_val;
        r_active_dp  <= r_shadow_dp;
      end

      if (load) begin
        r_busy <= 1'b1;
      end else if (w_boundary) begin
        r_busy <= 1'b0;
      end

      r_an         <= w_an_next;
      r_seg        <= w_seg_dec;
      r_dp         <= w_dp_next;
      r_frame_tick <= w_boundary;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign busy       = r_busy;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_controller
//   Directed bench for seg_scan_controller with DIGITS=4, DIV=8, BLANK=2.
//   A table of {value, dp, lz_suppress, lit mask, segment patterns} records
//   is applied through load + frame transfer. Each following frame is checked
//   slot by slot. Reset, load-on-boundary, enable gating and mid-frame reset
//   are covered by hand-written sequences.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_controller;
  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dpb;
    logic            lz;
    logic [3:0]      lit;
    logic [3:0][6:0] segs;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        enable;
  logic        lz_suppress;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[9];

  always #5 clk = ~clk;

  seg_scan_controller #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load        (load),
    .enable      (enable),
    .lz_suppress (lz_suppress),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .busy        (busy),
    .frame_tick  (frame_tick)
  );

  function automatic vec_t mk(input logic [15:0] val, input logic [3:0] dpb,
                              input logic lz, input logic [3:0] lit,
                              input logic [3:0][6:0] segs);
    vec_t v;
    v.val = val; v.dpb = dpb; v.lz = lz; v.lit = lit; v.segs = segs;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input bit ok, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called right after a frame_tick sample (or right after reset release):
  // the next 4*DIV samples are one whole frame, digit 0 first, and the last
  // sample carries the next frame_tick.
  task automatic capture_frame(input string tag, input logic [3:0][6:0] segs,
                               input logic [3:0] dpb, input logic [3:0] lit);
    bit         an_ok, seg_ok, dp_ok, tick_ok;
    logic [3:0] an_bad, an_exp_bad, exp_an;
    logic [6:0] seg_bad;
    logic       dp_bad, dp_exp_bad, exp_dp, exp_tick;
    tick_ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      an_ok = 1'b1; seg_ok = 1'b1; dp_ok = 1'b1;
      an_bad = '0; an_exp_bad = '0; seg_bad = '0; dp_bad = 1'b0; dp_exp_bad = 1'b0;
      for (int c = 0; c < DIV; c++) begin
        step();
        exp_an = 4'hF;
        exp_dp = 1'b1;
        if (c >= BLANK && lit[d]) begin
          exp_an[d] = 1'b0;
          exp_dp    = ~dpb[d];
        end
        exp_tick = (d == DIGITS - 1 && c == DIV - 1);
        if (an !== exp_an && an_ok) begin an_ok = 1'b0; an_bad = an; an_exp_bad = exp_an; end
        if (seg !== segs[d] && seg_ok) begin seg_ok = 1'b0; seg_bad = seg; end
        if (dp !== exp_dp && dp_ok) begin dp_ok = 1'b0; dp_bad = dp; dp_exp_bad = exp_dp; end
        if (frame_tick !== exp_tick) tick_ok = 1'b0;
      end
      chk($sformatf("%s an digit%0d", tag, d), an_ok, 32'(an_bad), 32'(an_exp_bad));
      chk($sformatf("%s seg digit%0d", tag, d), seg_ok, 32'(seg_bad), 32'(segs[d]));
      chk($sformatf("%s dp digit%0d", tag, d), dp_ok, 32'(dp_bad), 32'(dp_exp_bad));
    end
    chk($sformatf("%s frame_tick once at frame end", tag), tick_ok, 32'(frame_tick), 32'(1));
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * DIGITS * DIV && !seen; i++) begin
      step();
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    chk($sformatf("%s tick seen", tag), seen, 32'(seen), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(16'h1234, 4'b0001, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19});
    vecs[1] = mk(16'h0005, 4'b0000, 1'b1, 4'b0001, {7'h40, 7'h40, 7'h40, 7'h12});
    vecs[2] = mk(16'h0000, 4'b0000, 1'b1, 4'b0001, {7'h40, 7'h40, 7'h40, 7'h40});
    vecs[3] = mk(16'h0000, 4'b0000, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40});
    vecs[4] = mk(16'h0050, 4'b0000, 1'b1, 4'b0011, {7'h40, 7'h40, 7'h12, 7'h40});
    vecs[5] = mk(16'hABCD, 4'b1010, 1'b1, 4'b1111, {7'h08, 7'h03, 7'h46, 7'h21});
    vecs[6] = mk(16'hEF98, 4'b0100, 1'b0, 4'b1111, {7'h06, 7'h0E, 7'h10, 7'h00});
    vecs[7] = mk(16'h0700, 4'b1111, 1'b1, 4'b0111, {7'h40, 7'h78, 7'h40, 7'h40});
    vecs[8] = mk(16'h6000, 4'b0000, 1'b1, 4'b1111, {7'h02, 7'h40, 7'h40, 7'h40});

    // Reset with load and enable active: reset wins.
    reset = 1'b1; load = 1'b1; enable = 1'b1; lz_suppress = 1'b0;
    value_in = 16'hFFFF; dp_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset an c%0d", i), an === 4'hF, 32'(an), 32'hF);
      chk($sformatf("reset seg c%0d", i), seg === 7'h7F, 32'(seg), 32'h7F);
      chk($sformatf("reset dp c%0d", i), dp === 1'b1, 32'(dp), 32'h1);
      chk($sformatf("reset busy c%0d", i), busy === 1'b0, 32'(busy), 32'h0);
    end
    reset = 1'b0; load = 1'b0;
    capture_frame("post_reset", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 4'b1111);
    chk("post_reset busy", busy === 1'b0, 32'(busy), 32'h0);

    // Table-driven load / transfer / display.
    for (int v = 0; v < 9; v++) begin
      lz_suppress = vecs[v].lz;
      value_in    = vecs[v].val;
      dp_in       = vecs[v].dpb;
      load        = 1'b1;
      step();
      load = 1'b0;
      chk($sformatf("vec%0d busy after load", v), busy === 1'b1, 32'(busy), 32'h1);
      wait_tick($sformatf("vec%0d", v));
      chk($sformatf("vec%0d busy at tick", v), busy === 1'b0, 32'(busy), 32'h0);
      capture_frame($sformatf("vec%0d", v), vecs[v].segs, vecs[v].dpb, vecs[v].lit);
    end

    // Load on the boundary cycle while a value is pending.
    lz_suppress = 1'b0;
    value_in = 16'h5555; dp_in = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    chk("bnd busy after 5555", busy === 1'b1, 32'(busy), 32'h1);
    repeat (DIGITS * DIV - 2) step();
    value_in = 16'hAAAA; dp_in = 4'b1111; load = 1'b1;
    step();
    load = 1'b0;
    chk("bnd tick", frame_tick === 1'b1, 32'(frame_tick), 32'h1);
    chk("bnd busy stays", busy === 1'b1, 32'(busy), 32'h1);
    capture_frame("bnd5555", {7'h12, 7'h12, 7'h12, 7'h12}, 4'b0000, 4'b1111);
    chk("bnd busy cleared", busy === 1'b0, 32'(busy), 32'h0);
    capture_frame("bndAAAA", {7'h08, 7'h08, 7'h08, 7'h08}, 4'b1111, 4'b1111);

    // Enable dropped mid-slot of digit 2 for 10 cycles; load while dark.
    repeat (2 * DIV + 3) step();
    chk("en digit2 lit before drop", an === 4'b1011, 32'(an), 32'hB);
    enable = 1'b0;
    begin
      bit dark_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step();
        if (an !== 4'hF || dp !== 1'b1 || frame_tick !== 1'b0) dark_ok = 1'b0;
        if (i == 2) begin
          value_in = 16'h4321; dp_in = 4'b1000; load = 1'b1;
        end
        if (i == 3) begin
          load = 1'b0;
          chk("en load while dark", busy === 1'b1, 32'(busy), 32'h1);
        end
      end
      chk("en dark while disabled", dark_ok, 32'(an), 32'hF);
    end
    enable = 1'b1;
    capture_frame("reenable", {7'h08, 7'h08, 7'h08, 7'h08}, 4'b1111, 4'b1111);
    chk("reenable busy cleared", busy === 1'b0, 32'(busy), 32'h0);
    capture_frame("r4321", {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1000, 4'b1111);

    // Reset during digit 1 with a pending value.
    value_in = 16'h9999; dp_in = 4'b1111; load = 1'b1;
    step();
    load = 1'b0;
    chk("mid busy pending", busy === 1'b1, 32'(busy), 32'h1);
    repeat (DIV + 2) step();
    reset = 1'b1;
    step();
    chk("mid reset an", an === 4'hF, 32'(an), 32'hF);
    chk("mid reset seg", seg === 7'h7F, 32'(seg), 32'h7F);
    chk("mid reset busy", busy === 1'b0, 32'(busy), 32'h0);
    reset = 1'b0;
    capture_frame("mid_f1", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 4'b1111);
    chk("mid busy after frame", busy === 1'b0, 32'(busy), 32'h0);
    capture_frame("mid_f2", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
